// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared constants and types for the tug-of-war computer, light and victory stages
// Contents: LFSR width, feedback taps and reset value, cooldown length, press FSM state type.
package tow_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 9;
  localparam int TAP_B  = 6;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 10'h000;

  localparam int COOL_CYCLES = 3;
  localparam int COOL_W      = $clog2(COOL_CYCLES + 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOL_CYCLES);

  typedef enum logic {
    READY = 1'b0,
    COOL  = 1'b1
  } press_state_t;

endpackage

// File: rtl/lfsr10.sv
// rtl/lfsr10.sv - 10-bit XNOR-feedback LFSR that steps only when enabled
// Ports: clk (rising-edge clock), reset (async active-high, loads LFSR_RESET),
//        en (advance this cycle), q (current state).
module lfsr10
  import tow_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  // XNOR feedback makes all-zeros a legal start state; all-ones is the lock-up state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_RESET;
    end else if (en) begin
      q <= {q[LFSR_W-2:0], ~(q[TAP_A] ^ q[TAP_B])};
    end
  end

endmodule

// File: rtl/computer_press.sv
// rtl/computer_press.sv - pseudo-random computer button press generator with optional cooldown
// Ports: clk (rising-edge clock), reset (async active-high), enable (game running, 0 freezes),
//        difficulty[8:0] (press threshold, 0 = never press), press (registered one-cycle pulse),
//        lfsr_q[9:0] (current LFSR state).
// Build option: CPU_COOLDOWN_EN adds the COOL state and cooldown counter; without it the FSM
//        stays in READY and press follows the previous cycle's candidate.
module computer_press
  import tow_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [8:0]        difficulty,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  press_state_t state, state_next;
  logic         candidate;
  logic         press_next;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .q     (lfsr_q)
  );

  // Compare against the pre-edge LFSR value; difficulty is used unsynchronised.
  assign candidate = enable && ({1'b0, difficulty} > lfsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= READY;
      press <= 1'b0;
    end else begin
      state <= state_next;
      press <= press_next;
    end
  end

`ifdef CPU_COOLDOWN_EN
  logic [COOL_W-1:0] cool_cnt, cool_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cool_cnt <= '0;
    end else begin
      cool_cnt <= cool_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    cool_cnt_next = cool_cnt;
    press_next    = 1'b0;
    if (!enable) begin
      state_next    = READY;
      cool_cnt_next = '0;
    end else begin
      case (state)
        READY: begin
          if (candidate) begin
            press_next    = 1'b1;
            state_next    = COOL;
            cool_cnt_next = COOL_LOAD;
          end
        end
        COOL: begin
          // Leave COOL on the edge where the counter lands on zero so the
          // very next cycle can accept a fresh candidate.
          cool_cnt_next = cool_cnt - 1'b1;
          if (cool_cnt == COOL_W'(1)) begin
            state_next = READY;
          end
        end
        default: begin
          state_next    = READY;
          cool_cnt_next = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    state_next = READY;
    press_next = candidate && (state == READY);
  end
`endif

endmodule

// File: tb/tb_computer_press.sv
// tb/tb_computer_press.sv - self-checking bench for computer_press
module tb_computer_press;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [8:0] difficulty;
  logic       press;
  logic [9:0] lfsr_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       en;
    logic [8:0] diff;
    logic [9:0] exp_lfsr;
    logic       exp_press;
  } vec_t;

  vec_t vecs[13];

  computer_press dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .difficulty (difficulty),
    .press      (press),
    .lfsr_q     (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_next(input logic [9:0] q);
    return {q[8:0], ~(q[9] ^ q[6])};
  endfunction

  task automatic check(input string name, input logic [9:0] actual, input logic [9:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    difficulty = 9'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic en, input logic [8:0] d,
                         input logic [9:0] l, input logic p);
    vecs[i].en = en;
    vecs[i].diff = d;
    vecs[i].exp_lfsr = l;
    vecs[i].exp_press = p;
  endtask

  initial begin
    logic [9:0] q;
    logic       exp_p;

    n_checks = 0;
    n_fail = 0;

    // Sequence from reset, a 5-cycle freeze at 0x00F with high difficulty, then resume.
    set_vec(0, 1'b1, 9'd0, 10'h001, 1'b0);
    set_vec(1, 1'b1, 9'd0, 10'h003, 1'b0);
    set_vec(2, 1'b1, 9'd0, 10'h007, 1'b0);
    set_vec(3, 1'b1, 9'd0, 10'h00F, 1'b0);
    for (int i = 4; i < 9; i++) set_vec(i, 1'b0, 9'd511, 10'h00F, 1'b0);
    set_vec(9,  1'b1, 9'd0, 10'h01F, 1'b0);
    set_vec(10, 1'b1, 9'd0, 10'h03F, 1'b0);
    set_vec(11, 1'b1, 9'd0, 10'h07F, 1'b0);
    set_vec(12, 1'b1, 9'd0, 10'h0FE, 1'b0);

    reset = 1'b1;
    enable = 1'b0;
    difficulty = 9'd0;
    #3;
    check("reset_lfsr", lfsr_q, 10'h000);
    check("reset_press", {9'd0, press}, 10'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en;
      difficulty = vecs[i].diff;
      step();
      check($sformatf("vec%0d_lfsr", i), lfsr_q, vecs[i].exp_lfsr);
      check($sformatf("vec%0d_press", i), {9'd0, press}, {9'd0, vecs[i].exp_press});
    end

    // Threshold boundary at LFSR=0x003: difficulty 3 must not press, 4 must.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      enable = 1'b1;
      difficulty = 9'd0;
      step();
      step();
      check($sformatf("bnd%0d_pre_lfsr", t), lfsr_q, 10'h003);
      difficulty = (t == 0) ? 9'd3 : 9'd4;
      step();
      check($sformatf("bnd%0d_press", t), {9'd0, press}, (t == 0) ? 10'd0 : 10'd1);
      enable = 1'b0;
      step();
      check($sformatf("bnd%0d_disable_press", t), {9'd0, press}, 10'd0);
    end

    // Maximum difficulty from reset: cooldown spacing or back-to-back presses.
    do_reset();
    enable = 1'b1;
    difficulty = 9'd511;
    q = 10'h000;
    for (int k = 0; k < 10; k++) begin
`ifdef CPU_COOLDOWN_EN
      exp_p = ((k % 4) == 0) && (q < 10'd511);
`else
      exp_p = (q < 10'd511);
`endif
      step();
      q = lfsr_next(q);
      check($sformatf("max%0d_lfsr", k), lfsr_q, q);
      check($sformatf("max%0d_press", k), {9'd0, press}, {9'd0, exp_p});
    end

    // Asynchronous reset between edges right after a press, then READY on release.
    do_reset();
    enable = 1'b1;
    difficulty = 9'd511;
    step();
    check("mid_press", {9'd0, press}, 10'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_press", {9'd0, press}, 10'd0);
    check("mid_rst_lfsr", lfsr_q, 10'h000);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_press", {9'd0, press}, 10'd1);
    check("post_rst_lfsr", lfsr_q, 10'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/computer_press.md
COMPUTER_PRESS -- requirements
Module: computer_press

Interface
REQ-001 The module SHALL have port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 The module SHALL have port enable, input, 1, game running; 0 freezes the block.
REQ-004 The module SHALL have port difficulty, input, 9, press-probability threshold, zero-extended to 10 bits; 0 means the computer never presses.
REQ-005 The module SHALL have port press, output, 1, registered one-cycle press pulse driving the computer side's button input of the light stage.
REQ-006 The module SHALL have port lfsr_q, output, 10, current LFSR state, for debug and bench prediction.

Function
REQ-007 The LFSR SHALL be 10 bits wide, shift left each enabled cycle, and load bit0 with XNOR(q[9], q[6]).
- The all-ones state is the only lock-up state.
- From the reset value 0x000 the sequence is 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE, ...
REQ-008 The LFSR SHALL advance only in cycles where enable=1 and SHALL hold its value while enable=0.
REQ-009 A press candidate SHALL exist when enable=1 and {1'b0,difficulty} > lfsr_q, using an unsigned 10-bit compare on the pre-edge LFSR value.
REQ-010 press SHALL be registered: a candidate in cycle N SHALL produce press=1 in cycle N+1 only.
- Latency is one cycle.
- press SHALL never be high for two consecutive cycles when CPU_COOLDOWN_EN is defined.
REQ-011 The FSM SHALL have exactly two states, READY and COOL.
REQ-012 In READY, a candidate SHALL assert press next cycle.
- With CPU_COOLDOWN_EN defined, a candidate SHALL also move the FSM to COOL and load the cooldown counter with COOL_CYCLES.
REQ-013 In COOL, candidates SHALL be ignored (press=0) and the counter SHALL decrement once per enabled cycle.
- The FSM SHALL return to READY on the cycle the counter reaches 0.
- The first possible new candidate is the following cycle.
REQ-014 When enable falls, the block SHALL react on the next edge:
- press SHALL go to 0;
- the FSM SHALL go to READY;
- the cooldown counter SHALL clear to 0.
REQ-015 A difficulty change SHALL take effect in the same cycle's compare, with no synchronisation inside this block.
REQ-016 difficulty=0 SHALL never produce press, for every LFSR value.

Reset
REQ-017 Asserting reset SHALL immediately set the following, regardless of clk and of any cooldown in progress:
- lfsr_q=0x000;
- press=0;
- FSM=READY;
- cooldown counter=0.
REQ-018 After reset deasserts, the first enabled edge SHALL move the LFSR to 0x001.

Configuration
REQ-019 Macro CPU_COOLDOWN_EN SHALL, when defined, enable the COOL state and cooldown counter of REQ-012/013.
- Result: at most one press per COOL_CYCLES+1 enabled cycles.
REQ-020 When CPU_COOLDOWN_EN is undefined, the FSM SHALL remain in READY.
- The counter logic SHALL be absent.
- press SHALL equal the previous cycle's candidate, so it may stay high on consecutive cycles.

Structure
REQ-021 Shared package tow_pkg SHALL hold the following, for use by this block and the light and victory stages:
- LFSR_W=10;
- tap positions 9 and 6;
- LFSR_RESET=10'h000;
- COOL_CYCLES=3;
- the FSM state enum type.
REQ-022 The LFSR SHALL be a separate sub-module lfsr10 with ports clk, reset, en, q.
- computer_press SHALL instantiate it once.

Verification
REQ-023 Reset-to-sequence check: reset, then enable=1 with difficulty=0 -> lfsr_q steps 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE, and press stays 0 throughout.
REQ-024 Cooldown check (CPU_COOLDOWN_EN defined): difficulty=511, enable=1 from reset -> press=1 in the cycle after the first enabled edge, then 0 for 3 cycles even though candidates persist, then 1 again.
REQ-025 Back-to-back check (CPU_COOLDOWN_EN undefined): same stimulus as REQ-024 -> press high on every cycle while lfsr_q < 511.
REQ-026 Freeze check: enable dropped for 5 cycles while lfsr_q=0x00F -> lfsr_q holds 0x00F, press=0, and after re-enable the next value is 0x01F.
REQ-027 Mid-cooldown reset: reset asserted asynchronously between edges while in COOL -> press=0 and lfsr_q=0x000 immediately, and after release the FSM is in READY.
REQ-028 Threshold boundary: hold the LFSR at 0x003 (enable pulsed) with difficulty=3 -> no press; with difficulty=4 -> press the next cycle.
